// File: rtl/ddr5_dram_pkg.sv
// ddr5_dram_pkg: opcodes, FSM states and ca field positions
// shared by the DDR5 device model files.
package ddr5_dram_pkg;

  typedef enum logic [2:0] {
    OP_ACT = 3'b000,
    OP_RD  = 3'b001,
    OP_WR  = 3'b010,
    OP_PRE = 3'b011,
    OP_REF = 3'b100,
    OP_NOP = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_REFRESH
  } state_e;

  localparam int CA_OP_LSB   = 0;
  localparam int CA_OP_W     = 3;
  localparam int CA_BANK_LSB = 3;

endpackage

// File: rtl/ddr5_bank_tracker.sv
// ddr5_bank_tracker: per-bank open flag and open row,
// updated by ACT, PRE and PRE-all.
module ddr5_bank_tracker
  import ddr5_dram_pkg::*;
#(
  parameter int BANKS  = 4,
  parameter int BANK_W = 2,
  parameter int ROW_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              act_i,
  input  logic              pre_i,
  input  logic              pre_all_i,
  input  logic [BANK_W-1:0] bank_i,
  input  logic [ROW_W-1:0]  row_i,
  output logic [BANKS-1:0]  bank_open_o,
  output logic [ROW_W-1:0]  open_row_o,
  output logic              all_closed_o
);

  logic [BANKS-1:0]            open_q, open_d;
  logic [BANKS-1:0][ROW_W-1:0] row_q, row_d;

  // Next bank state from the accepted ACT/PRE command.
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    if (act_i) begin
      open_d[bank_i] = 1'b1;
      row_d[bank_i]  = row_i;
    end
    if (pre_i) begin
      if (pre_all_i) open_d = '0;
      else           open_d[bank_i] = 1'b0;
    end
  end

  // Bank state registers; reset closes every bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      open_q <= '0;
      row_q  <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

  assign bank_open_o  = open_q;
  assign open_row_o   = row_q[bank_i];
  assign all_closed_o = ~|open_q;

endmodule

// File: rtl/ddr5_dram_core.sv
// ddr5_dram_core: cycle-level DDR5 device model (decoder, FSM, array).
// Optional CA parity check: define DDR5_DRAM_CA_PARITY_EN.
module ddr5_dram_core
  import ddr5_dram_pkg::*;
#(
  parameter int DQ_W  = 16,
  parameter int CA_W  = 14,
  parameter int BANKS = 4,
  parameter int ROW_W = 6,
  parameter int COL_W = 4,
  parameter int CL    = 6,
  parameter int CWL   = 4,
  parameter int BL    = 8,
  parameter int TRFC  = 16
) (
  input  logic            ck_t,
  input  logic            rst,
  input  logic            cs_n,
  input  logic [CA_W-1:0] ca,
  input  logic [DQ_W-1:0] dq_in,
`ifdef DDR5_DRAM_CA_PARITY_EN
  input  logic            ca_par,
  output logic            alert,
`endif
  output logic [DQ_W-1:0] dq_out,
  output logic            dq_oe,
  output logic            dqs_t,
  output logic            busy,
  output logic            cmd_err
);

  localparam int BANK_W   = $clog2(BANKS);
  localparam int AW       = BANK_W + ROW_W + COL_W;
  localparam int DEPTH    = BANKS * (2 ** (ROW_W + COL_W));
  localparam int ADDR_LSB = CA_BANK_LSB + BANK_W;
  localparam int CNT_W    = $clog2(TRFC + CL + CWL);
  localparam logic [COL_W-1:0] BL_MASK = COL_W'(BL - 1);

  opcode_e           op;
  logic [BANK_W-1:0] cmd_bank;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;
  logic              cmd_pall, cmd_v, par_err;
  logic              unused_ca;

  logic [BANKS-1:0]  bank_open;
  logic [ROW_W-1:0]  open_row;
  logic              all_closed;
  logic              act_en, pre_en, rw_go, ref_go, last_beat;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [COL_W-1:0]  beat_q, beat_d, col_q, col_d;
  logic              dir_q, dir_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DQ_W-1:0]   dq_out_q, dq_out_d;
  logic              oe_q, oe_d, dqs_q, dqs_d, err_q, err_d;

  logic [COL_W-1:0]  col_beat;
  logic [AW-1:0]     addr;
  logic              rd_beat, wr_beat;
  logic [DQ_W-1:0]   mem [DEPTH];

  assign op        = opcode_e'(ca[CA_OP_LSB +: CA_OP_W]);
  assign cmd_bank  = ca[CA_BANK_LSB +: BANK_W];
  assign cmd_row   = ca[ADDR_LSB +: ROW_W];
  assign cmd_col   = ca[ADDR_LSB +: COL_W];
  assign cmd_pall  = ca[CA_W-1];
  assign unused_ca = ^ca;

`ifdef DDR5_DRAM_CA_PARITY_EN
  logic alert_q;
  assign par_err = !cs_n && (^{ca, ca_par});

  // Alert pulses the cycle after a parity-failed command.
  always_ff @(posedge ck_t) begin
    if (rst) alert_q <= 1'b0;
    else     alert_q <= par_err;
  end
  assign alert = alert_q;
`else
  assign par_err = 1'b0;
`endif

  assign cmd_v = !cs_n && !par_err;

  ddr5_bank_tracker #(
    .BANKS (BANKS),
    .BANK_W(BANK_W),
    .ROW_W (ROW_W)
  ) u_banks (
    .clk_i       (ck_t),
    .rst_i       (rst),
    .act_i       (act_en),
    .pre_i       (pre_en),
    .pre_all_i   (cmd_pall),
    .bank_i      (cmd_bank),
    .row_i       (cmd_row),
    .bank_open_o (bank_open),
    .open_row_o  (open_row),
    .all_closed_o(all_closed)
  );

  assign last_beat = (state_q == S_BURST) && (beat_q == BL_MASK);
  assign rd_beat   = (state_q == S_BURST) && !dir_q;
  assign wr_beat   = (state_q == S_BURST) && dir_q;
  assign col_beat  = (col_q & ~BL_MASK) | ((col_q + beat_q) & BL_MASK);
  assign addr      = {bank_q, row_q, col_beat};

  // Command decode: accept or reject the presented command.
  always_comb begin
    act_en = 1'b0;
    pre_en = 1'b0;
    rw_go  = 1'b0;
    ref_go = 1'b0;
    err_d  = par_err;
    if (cmd_v) begin
      unique case (op)
        OP_ACT: begin
          if (state_q == S_REFRESH || bank_open[cmd_bank]) err_d = 1'b1;
          else act_en = 1'b1;
        end
        OP_PRE: begin
          if (state_q == S_REFRESH) err_d = 1'b1;
          else pre_en = 1'b1;
        end
        OP_RD, OP_WR: begin
          if (bank_open[cmd_bank] && (state_q == S_IDLE || last_beat))
            rw_go = 1'b1;
          else
            err_d = 1'b1;
        end
        OP_REF: begin
          if (state_q == S_IDLE && all_closed) ref_go = 1'b1;
          else err_d = 1'b1;
        end
        OP_NOP: ;
        default: err_d = 1'b1;
      endcase
    end
  end

  // FSM next state, burst bookkeeping and registered read outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    dir_d   = dir_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    if (rw_go) begin
      state_d = S_WAIT;
      dir_d   = (op == OP_WR);
      bank_d  = cmd_bank;
      row_d   = open_row;
      col_d   = cmd_col;
      cnt_d   = (op == OP_WR) ? CNT_W'(CWL - 2) : CNT_W'(CL - 2);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ref_go) begin
            state_d = S_REFRESH;
            cnt_d   = CNT_W'(TRFC - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_d = S_BURST;
            beat_d  = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_BURST: begin
          beat_d = beat_q + COL_W'(1);
          if (last_beat) state_d = S_IDLE;
        end
        S_REFRESH: begin
          if (cnt_q == '0) state_d = S_IDLE;
          else cnt_d = cnt_q - CNT_W'(1);
        end
      endcase
    end
    oe_d     = rd_beat;
    dqs_d    = rd_beat && !beat_q[0];
    dq_out_d = rd_beat ? mem[addr] : '0;
  end

  // State and output registers; reset aborts any burst.
  always_ff @(posedge ck_t) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      dir_q    <= 1'b0;
      bank_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      dq_out_q <= '0;
      oe_q     <= 1'b0;
      dqs_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      dir_q    <= dir_d;
      bank_q   <= bank_d;
      row_q    <= row_d;
      col_q    <= col_d;
      dq_out_q <= dq_out_d;
      oe_q     <= oe_d;
      dqs_q    <= dqs_d;
      err_q    <= err_d;
    end
  end

  // Array write on each write beat; contents survive reset.
  always_ff @(posedge ck_t) begin
    if (!rst && wr_beat) mem[addr] <= dq_in;
  end

  assign dq_out  = dq_out_q;
  assign dq_oe   = oe_q;
  assign dqs_t   = dqs_q;
  assign cmd_err = err_q;
  assign busy    = (state_q != S_IDLE);

endmodule
